// File: rtl/down_timer_if.sv
// Control and status bundle for the down_timer block.
// The master side issues load/start/stop/pause requests; the timer reports count, busy and done.
interface down_timer_if #(
    parameter int unsigned WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             pause;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    modport master (
        output load, load_val, start, stop, pause, auto_reload,
        input  count, busy, done
    );

    modport slave (
        input  load, load_val, start, stop, pause, auto_reload,
        output count, busy, done
    );
endinterface : down_timer_if

// File: rtl/down_timer.sv
// Loadable down-counter/timer with one-shot and auto-reload modes, pause and stop.
// Decrements once per clock while running and emits a one-cycle registered done pulse at terminal count.
module down_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    down_timer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic count_is_zero;
    logic count_is_one;
    logic reload_enabled;

    assign count_is_zero  = (count_q == ZERO);
    assign count_is_one   = (count_q == ONE);
    assign reload_enabled = bus.auto_reload && (reload_q != ZERO);

    // State register: all state, including the registered busy/done outputs.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state logic; request priority is load > stop > start > pause > decrement.
    always_comb begin
        // NOTE: every signal gets a default up front so no path through the case infers a latch.
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (bus.load) begin
            count_d  = bus.load_val;
            reload_d = bus.load_val;
            state_d  = IDLE;
        end else if (bus.stop && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (count_is_zero) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end

                RUN: begin
                    if (bus.pause) begin
                        state_d = HOLD;
                    end else if (count_is_one) begin
                        done_d = 1'b1;
                        if (reload_enabled) begin
                            count_d = reload_q;
                        end else begin
                            count_d = ZERO;
                            state_d = IDLE;
                        end
                    end else if (count_is_zero) begin
                        // Unreachable by construction; park safely rather than wrap.
                        state_d = IDLE;
                    end else begin
                        count_d = count_q - ONE;
                    end
                end

                HOLD: begin
                    if (!bus.pause) begin
                        state_d = RUN;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d == RUN) || (state_d == HOLD);
    end

    // Outputs come straight from registers so they are glitch-free.
    always_comb begin
        bus.count = count_q;
        bus.busy  = busy_q;
        bus.done  = done_q;
    end

endmodule : down_timer

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: a table of hand-derived vectors, corner-case
// sequences, and a randomized run against a rule-level reference model.
module tb_down_timer;

    localparam int unsigned W = 4;

    logic clk;
    logic reset_n;

    down_timer_if #(.WIDTH(W)) ifc ();

    down_timer #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: timer described as "armed" (counting or paused) plus a paused flag.
    int m_count;
    int m_reload;
    bit m_armed;
    bit m_paused;
    bit m_done;

    function automatic void model_reset();
        m_count  = 0;
        m_reload = 0;
        m_armed  = 0;
        m_paused = 0;
        m_done   = 0;
    endfunction

    function automatic void model_step(input bit ld, input int lv, input bit st,
                                       input bit sp, input bit pa, input bit ar);
        m_done = 0;
        if (ld) begin
            m_count  = lv;
            m_reload = lv;
            m_armed  = 0;
            m_paused = 0;
        end else if (sp && m_armed) begin
            m_armed  = 0;
            m_paused = 0;
        end else if (!m_armed) begin
            if (st) begin
                if (m_count == 0) m_done = 1;
                else              m_armed = 1;
            end
        end else if (m_paused) begin
            if (!pa) m_paused = 0;
        end else if (pa) begin
            m_paused = 1;
        end else if (m_count == 1) begin
            m_done = 1;
            if (ar && m_reload != 0) begin
                m_count = m_reload;
            end else begin
                m_count = 0;
                m_armed = 0;
            end
        end else begin
            m_count = m_count - 1;
        end
    endfunction

    // Drive one cycle at the falling edge, advance the model at the rising edge, settle 1 time unit.
    task automatic tick(input bit ld, input logic [W-1:0] lv, input bit st,
                        input bit sp, input bit pa, input bit ar);
        @(negedge clk);
        ifc.load        = ld;
        ifc.load_val    = lv;
        ifc.start       = st;
        ifc.stop        = sp;
        ifc.pause       = pa;
        ifc.auto_reload = ar;
        @(posedge clk);
        model_step(ld, int'(lv), st, sp, pa, ar);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_count"}, 32'(ifc.count), 32'(m_count));
        check({tag, "_busy"},  32'(ifc.busy),  32'(m_armed));
        check({tag, "_done"},  32'(ifc.done),  32'(m_done));
    endtask

    typedef struct {
        bit           ld;
        logic [W-1:0] lv;
        bit           st;
        bit           sp;
        bit           pa;
        bit           ar;
        logic [W-1:0] ec;
        bit           eb;
        bit           ed;
    } vec_t;

    localparam int NVEC = 31;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input bit ld, input int lv, input bit st, input bit sp,
                                input bit pa, input bit ar, input int ec, input bit eb, input bit ed);
        vec_t v;
        v.ld = ld; v.lv = W'(lv); v.st = st; v.sp = sp; v.pa = pa; v.ar = ar;
        v.ec = W'(ec); v.eb = eb; v.ed = ed;
        return v;
    endfunction

    initial begin
        //            ld lv st sp pa ar  cnt busy done
        vecs[0]  = mk(1, 5, 0, 0, 0, 0,  5, 0, 0);
        vecs[1]  = mk(0, 0, 1, 0, 0, 0,  5, 1, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0,  4, 1, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0,  3, 1, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0,  2, 1, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0,  1, 1, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 1);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0);
        vecs[8]  = mk(1, 3, 0, 0, 0, 1,  3, 0, 0);
        vecs[9]  = mk(0, 0, 1, 0, 0, 1,  3, 1, 0);
        vecs[10] = mk(0, 0, 0, 0, 0, 1,  2, 1, 0);
        vecs[11] = mk(0, 0, 0, 0, 0, 1,  1, 1, 0);
        vecs[12] = mk(0, 0, 0, 0, 0, 1,  3, 1, 1);
        vecs[13] = mk(0, 0, 0, 0, 0, 1,  2, 1, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 1,  1, 1, 0);
        vecs[15] = mk(0, 0, 0, 0, 0, 0,  0, 0, 1);
        vecs[16] = mk(0, 0, 1, 0, 0, 0,  0, 0, 1);
        vecs[17] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0);
        vecs[18] = mk(1, 7, 0, 1, 0, 0,  7, 0, 0);
        vecs[19] = mk(0, 0, 1, 0, 0, 0,  7, 1, 0);
        vecs[20] = mk(0, 0, 0, 0, 0, 0,  6, 1, 0);
        vecs[21] = mk(1, 9, 0, 1, 0, 0,  9, 0, 0);
        vecs[22] = mk(0, 0, 1, 0, 0, 0,  9, 1, 0);
        vecs[23] = mk(0, 0, 0, 0, 1, 0,  9, 1, 0);
        vecs[24] = mk(0, 0, 0, 0, 1, 0,  9, 1, 0);
        vecs[25] = mk(0, 0, 0, 0, 0, 0,  9, 1, 0);
        vecs[26] = mk(0, 0, 0, 0, 0, 0,  8, 1, 0);
        vecs[27] = mk(0, 0, 0, 1, 0, 0,  8, 0, 0);
        vecs[28] = mk(0, 0, 0, 1, 0, 0,  8, 0, 0);
        vecs[29] = mk(0, 0, 1, 0, 0, 0,  8, 1, 0);
        vecs[30] = mk(0, 0, 0, 0, 0, 0,  7, 1, 0);
    end

    initial begin
        int  k;
        bit  seen;
        bit  ar;

        reset_n         = 1'b0;
        ifc.load        = 1'b0;
        ifc.load_val    = '0;
        ifc.start       = 1'b0;
        ifc.stop        = 1'b0;
        ifc.pause       = 1'b0;
        ifc.auto_reload = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_count", 32'(ifc.count), 0);
        check("reset_busy",  32'(ifc.busy),  0);
        check("reset_done",  32'(ifc.done),  0);
        reset_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
            tick(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].sp, vecs[i].pa, vecs[i].ar);
            check($sformatf("vec%0d_count", i), 32'(ifc.count), 32'(vecs[i].ec));
            check($sformatf("vec%0d_busy", i),  32'(ifc.busy),  32'(vecs[i].eb));
            check($sformatf("vec%0d_done", i),  32'(ifc.done),  32'(vecs[i].ed));
        end

        // Asynchronous reset mid-count
        tick(1, 9, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0);
        repeat (3) tick(0, 0, 0, 0, 0, 0);
        check("pre_reset_count", 32'(ifc.count), 6);
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_count", 32'(ifc.count), 0);
        check("async_rst_busy",  32'(ifc.busy),  0);
        check("async_rst_done",  32'(ifc.done),  0);
        @(negedge clk);
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        check("in_rst_busy", 32'(ifc.busy), 0);
        check("in_rst_done", 32'(ifc.done), 0);
        @(negedge clk);
        ifc.start = 1'b0;
        reset_n   = 1'b1;
        tick(0, 0, 0, 0, 0, 0);
        check_model("post_rst");
        check("post_rst_count", 32'(ifc.count), 0);

        // Maximum load value: done exactly 15 cycles after RUN entry, then no underflow
        tick(1, 15, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0);
        k    = 0;
        seen = 0;
        while (!seen && k < 40) begin
            tick(0, 0, 0, 0, 0, 0);
            k++;
            check_model($sformatf("max_c%0d", k));
            seen = ifc.done;
        end
        check("max_done_latency", 32'(k), 15);
        tick(0, 0, 0, 0, 0, 0);
        check("max_no_underflow", 32'(ifc.count), 0);
        check("max_idle_busy",    32'(ifc.busy),  0);

        // Pause at 10, resume, stop at 6, restart
        tick(1, 15, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0);
        k = 0;
        while (ifc.count != 10 && k < 20) begin
            tick(0, 0, 0, 0, 0, 0);
            k++;
        end
        check("reach_10", 32'(ifc.count), 10);
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0, 1, 0);
            check($sformatf("hold%0d_count", i), 32'(ifc.count), 10);
            check($sformatf("hold%0d_busy", i),  32'(ifc.busy),  1);
            check($sformatf("hold%0d_done", i),  32'(ifc.done),  0);
        end
        tick(0, 0, 0, 0, 0, 0);
        check_model("unpause");
        tick(0, 0, 0, 0, 0, 0);
        check("resume_9", 32'(ifc.count), 9);
        k = 0;
        while (ifc.count != 6 && k < 20) begin
            tick(0, 0, 0, 0, 0, 0);
            k++;
        end
        tick(0, 0, 0, 1, 0, 0);
        check("stop_count", 32'(ifc.count), 6);
        check("stop_busy",  32'(ifc.busy),  0);
        check("stop_done",  32'(ifc.done),  0);
        tick(0, 0, 1, 0, 0, 0);
        check_model("restart");
        tick(0, 0, 0, 0, 0, 0);
        check("restart_5", 32'(ifc.count), 5);

        // Randomized traffic against the reference model
        ar = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) ar = ~ar;
            tick($urandom_range(0, 15) == 0,
                 W'($urandom_range(0, 15)),
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) == 0,
                 ar);
            check_model($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_down_timer
